// File: rtl/score_pkg.sv
// Shared encodings for the game-flow controller: FSM state codes and the
// saturation value of the 6-digit BCD score.
package score_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_OVER  = 2'b11
   } state_t;

   localparam logic [23:0] BCD_MAX = 24'h999999;

endpackage

// File: rtl/game_score_rise_detect.sv
// Single-register rising-edge detector for a level input already synchronous to clk.
// The first pulse appears in the same cycle the input goes high.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic i_sig,
   output logic o_rise
);

   logic r_sig_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_sig_q <= 1'b0;
      else        r_sig_q <= i_sig;
   end

   assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/game_score_ctrl.sv
// Game-flow controller: IDLE/RUN/PAUSE/OVER sequencing, score tick generation
// with progressive speed-up, and the session high-score register.
module game_score_ctrl
   import score_pkg::*;
#(
   parameter int CNT_W       = 26,
   parameter int TICK_DIV    = 50_000_000,
   parameter int MIN_DIV     = 12_500_000,
   parameter int DIV_STEP    = 2_500_000,
   parameter int SPEEDUP_PTS = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        pause,
   input  logic        collision,
   input  logic [23:0] score_bcd,
   output logic        score_inc,
   output logic        score_clr,
   output logic [1:0]  state,
   output logic        running,
   output logic [23:0] hiscore_bcd,
   output logic        new_hiscore
);

   localparam int PTS_W = $clog2(SPEEDUP_PTS + 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_tick_cnt;
   logic [CNT_W-1:0]   r_period;
   logic [PTS_W-1:0]   r_pts_cnt;
   logic               r_over_c0;
   logic [23:0]        r_hiscore;
   logic               r_new_hi;

   logic               w_start_rise;
   logic               w_pause_rise;
   logic               w_tick_due;
   logic               w_tick_run;
   logic               w_launch;
   logic               w_inc;
   logic               w_clr;

   // Period shrinks by DIV_STEP but never below MIN_DIV; compared before subtracting so it cannot wrap.
   function automatic logic [CNT_W-1:0] f_next_period(input logic [CNT_W-1:0] p);
      if (p > CNT_W'(MIN_DIV + DIV_STEP)) return p - CNT_W'(DIV_STEP);
      else                                return CNT_W'(MIN_DIV);
   endfunction

   rise_detect u_start_rise (
      .clk   (clk),
      .reset (reset),
      .i_sig (start),
      .o_rise(w_start_rise)
   );

   rise_detect u_pause_rise (
      .clk   (clk),
      .reset (reset),
      .i_sig (pause),
      .o_rise(w_pause_rise)
   );

   assign w_tick_due = (r_tick_cnt == (r_period - CNT_W'(1)));

   always_comb begin
      w_state_nxt = r_state;
      w_tick_run  = 1'b0;
      w_launch    = 1'b0;
      w_inc       = 1'b0;
      w_clr       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_rise) begin
               w_state_nxt = ST_RUN;
               w_launch    = 1'b1;
               w_clr       = 1'b1;
            end
         end
         ST_RUN: begin
            if (collision) begin
               w_state_nxt = ST_OVER;
            end else if (w_pause_rise) begin
               w_state_nxt = ST_PAUSE;
            end else begin
               w_tick_run = 1'b1;
               w_inc      = w_tick_due && (score_bcd != BCD_MAX);
            end
         end
         ST_PAUSE: begin
            if (w_pause_rise) w_state_nxt = ST_RUN;
         end
         ST_OVER: begin
            // The entry cycle is reserved for the high-score compare.
            if (!r_over_c0 && w_start_rise) begin
               w_state_nxt = ST_RUN;
               w_launch    = 1'b1;
               w_clr       = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_over_c0 <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_over_c0 <= (w_state_nxt == ST_OVER) && (r_state != ST_OVER);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tick_cnt <= '0;
         r_period   <= CNT_W'(TICK_DIV);
         r_pts_cnt  <= '0;
      end else if (w_launch) begin
         r_tick_cnt <= '0;
         r_period   <= CNT_W'(TICK_DIV);
         r_pts_cnt  <= '0;
      end else if (w_tick_run) begin
         // Wrap continues even when saturated so the cadence is kept.
         r_tick_cnt <= w_tick_due ? '0 : r_tick_cnt + CNT_W'(1);
         if (w_inc) begin
            if (r_pts_cnt == PTS_W'(SPEEDUP_PTS - 1)) begin
               r_pts_cnt <= '0;
               r_period  <= f_next_period(r_period);
            end else begin
               r_pts_cnt <= r_pts_cnt + PTS_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hiscore <= '0;
         r_new_hi  <= 1'b0;
      end else if ((r_state == ST_OVER) && r_over_c0) begin
         if (score_bcd > r_hiscore) begin
            r_hiscore <= score_bcd;
            r_new_hi  <= 1'b1;
         end else begin
            r_new_hi  <= 1'b0;
         end
      end else if (w_launch) begin
         r_new_hi <= 1'b0;
      end
   end

   assign score_inc   = w_inc;
   assign score_clr   = w_clr;
   assign state       = r_state;
   assign running     = (r_state == ST_RUN);
   assign hiscore_bcd = r_hiscore;
   assign new_hiscore = r_new_hi;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Directed bench for game_score_ctrl with a short tick period (10, floor 4, step 2, 3 pts).
module tb_game_score_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        collision = 1'b0;
   logic [23:0] score_bcd = 24'h0;
   logic        score_inc;
   logic        score_clr;
   logic [1:0]  state;
   logic        running;
   logic [23:0] hiscore_bcd;
   logic        new_hiscore;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   game_score_ctrl #(
      .CNT_W      (26),
      .TICK_DIV   (10),
      .MIN_DIV    (4),
      .DIV_STEP   (2),
      .SPEEDUP_PTS(3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pause      (pause),
      .collision  (collision),
      .score_bcd  (score_bcd),
      .score_inc  (score_inc),
      .score_clr  (score_clr),
      .state      (state),
      .running    (running),
      .hiscore_bcd(hiscore_bcd),
      .new_hiscore(new_hiscore)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Cycles from the current cycle until the next score_inc; -1 if none within 100.
   task automatic wait_inc(output int n);
      n = 0;
      do begin
         cyc();
         #1;
         n++;
      end while (!score_inc && n < 100);
      if (!score_inc) n = -1;
   endtask

   task automatic do_reset();
      cyc();
      reset = 1'b0;
      #1;
      cyc();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) cyc();
      #1;
      n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state got %b want 00", state); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running got %b want 0", running); end
      n_cmp++; if ({score_inc, score_clr} !== 2'b00) begin n_bad++; $display("FAIL reset_enables got %b want 00", {score_inc, score_clr}); end
      n_cmp++; if (hiscore_bcd !== 24'h0) begin n_bad++; $display("FAIL reset_hiscore got %h want 000000", hiscore_bcd); end
      n_cmp++; if (new_hiscore !== 1'b0) begin n_bad++; $display("FAIL reset_new_hi got %b want 0", new_hiscore); end
      cyc();
      reset = 1'b1;
   endtask

   task automatic test_start_speedup();
      int n;
      int exp_gap[13] = '{10, 10, 10, 8, 8, 8, 6, 6, 6, 4, 4, 4, 4};
      cyc();
      start = 1'b1;
      #1;
      n_cmp++; if (score_clr !== 1'b1) begin n_bad++; $display("FAIL start_clr got %b want 1", score_clr); end
      cyc();
      #1;
      n_cmp++; if (score_clr !== 1'b0) begin n_bad++; $display("FAIL clr_one_cycle got %b want 0", score_clr); end
      n_cmp++; if ({state, running} !== 3'b011) begin n_bad++; $display("FAIL start_run got state %b running %b want 01 1", state, running); end
      start = 1'b0;
      wait_inc(n);
      n_cmp++; if (n + 1 !== exp_gap[0]) begin n_bad++; $display("FAIL first_inc got %0d want %0d", n + 1, exp_gap[0]); end
      for (int i = 1; i < 13; i++) begin
         wait_inc(n);
         n_cmp++; if (n !== exp_gap[i]) begin n_bad++; $display("FAIL gap_%0d got %0d want %0d", i, n, exp_gap[i]); end
      end
   endtask

   task automatic test_pause();
      int n;
      int bad_cycles;
      do_reset();
      cyc();
      start = 1'b1;
      #1;
      cyc();
      start = 1'b0;
      repeat (4) cyc();
      cyc();
      pause = 1'b1;
      #1;
      n_cmp++; if ({state, score_inc} !== 3'b010) begin n_bad++; $display("FAIL pause_edge_cycle got state %b inc %b want 01 0", state, score_inc); end
      cyc();
      pause = 1'b0;
      #1;
      n_cmp++; if ({state, running} !== 3'b100) begin n_bad++; $display("FAIL paused got state %b running %b want 10 0", state, running); end
      bad_cycles = 0;
      for (int i = 0; i < 18; i++) begin
         cyc();
         start     = (i == 4);
         collision = (i == 9);
         #1;
         if (score_inc || score_clr || state != 2'b10) bad_cycles++;
      end
      n_cmp++; if (bad_cycles !== 0) begin n_bad++; $display("FAIL pause_hold got %0d bad cycles want 0", bad_cycles); end
      cyc();
      pause = 1'b1;
      #1;
      wait_inc(n);
      pause = 1'b0;
      n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL resume_inc got %0d want 5", n); end
      n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL resume_state got %b want 01", state); end
   endtask

   task automatic test_collision();
      int early;
      score_bcd = 24'h000042;
      early = 0;
      repeat (9) begin
         cyc();
         #1;
         if (score_inc) early++;
      end
      n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL pre_collision_incs got %0d want 0", early); end
      cyc();
      collision = 1'b1;
      #1;
      n_cmp++; if ({state, score_inc} !== 3'b010) begin n_bad++; $display("FAIL collision_tick got state %b inc %b want 01 0", state, score_inc); end
      cyc();
      collision = 1'b0;
      #1;
      n_cmp++; if ({state, running} !== 3'b110) begin n_bad++; $display("FAIL over_state got state %b running %b want 11 0", state, running); end
      cyc();
      #1;
      n_cmp++; if (hiscore_bcd !== 24'h000042) begin n_bad++; $display("FAIL hiscore_set got %h want 000042", hiscore_bcd); end
      n_cmp++; if (new_hiscore !== 1'b1) begin n_bad++; $display("FAIL new_hi_set got %b want 1", new_hiscore); end
   endtask

   task automatic test_second_game();
      start = 1'b1;
      #1;
      n_cmp++; if (score_clr !== 1'b1) begin n_bad++; $display("FAIL restart_clr got %b want 1", score_clr); end
      cyc();
      start = 1'b0;
      score_bcd = 24'h0;
      #1;
      n_cmp++; if ({state, new_hiscore} !== 3'b010) begin n_bad++; $display("FAIL restart got state %b new_hi %b want 01 0", state, new_hiscore); end
      repeat (3) cyc();
      cyc();
      score_bcd = 24'h000017;
      collision = 1'b1;
      #1;
      cyc();
      collision = 1'b0;
      start = 1'b1;
      #1;
      n_cmp++; if ({state, score_clr} !== 3'b110) begin n_bad++; $display("FAIL over_c0_start got state %b clr %b want 11 0", state, score_clr); end
      cyc();
      #1;
      n_cmp++; if ({state, score_clr} !== 3'b110) begin n_bad++; $display("FAIL held_start got state %b clr %b want 11 0", state, score_clr); end
      n_cmp++; if (hiscore_bcd !== 24'h000042) begin n_bad++; $display("FAIL hiscore_kept got %h want 000042", hiscore_bcd); end
      n_cmp++; if (new_hiscore !== 1'b0) begin n_bad++; $display("FAIL new_hi_clear got %b want 0", new_hiscore); end
      cyc();
      start = 1'b0;
      cyc();
      start = 1'b1;
      #1;
      n_cmp++; if (score_clr !== 1'b1) begin n_bad++; $display("FAIL over_c1_start got %b want 1", score_clr); end
      cyc();
      start = 1'b0;
      #1;
      n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL over_to_run got %b want 01", state); end
   endtask

   task automatic test_saturate_reset();
      int incs;
      int n;
      score_bcd = 24'h999999;
      incs = 0;
      repeat (40) begin
         cyc();
         #1;
         if (score_inc) incs++;
      end
      n_cmp++; if (incs !== 0) begin n_bad++; $display("FAIL saturate got %0d incs want 0", incs); end
      score_bcd = 24'h000123;
      wait_inc(n);
      n_cmp++; if (n < 1 || n > 10) begin n_bad++; $display("FAIL unsat_inc got %0d want 1..10", n); end
      cyc();
      reset = 1'b0;
      #1;
      n_cmp++; if ({state, running, score_inc, score_clr, new_hiscore} !== 6'b0) begin n_bad++; $display("FAIL async_reset_ctl got %b want 000000", {state, running, score_inc, score_clr, new_hiscore}); end
      n_cmp++; if (hiscore_bcd !== 24'h0) begin n_bad++; $display("FAIL async_reset_hi got %h want 000000", hiscore_bcd); end
      cyc();
      reset = 1'b1;
   endtask

   task automatic test_back_to_back();
      int n;
      score_bcd = 24'h0;
      cyc();
      start = 1'b1;
      #1;
      n_cmp++; if (score_clr !== 1'b1) begin n_bad++; $display("FAIL b2b_clr got %b want 1", score_clr); end
      cyc();
      start = 1'b0;
      #1;
      wait_inc(n);
      n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL b2b_first_inc got %0d want 9", n); end
   endtask

   initial begin
      test_reset();
      test_start_speedup();
      test_pause();
      test_collision();
      test_second_game();
      test_saturate_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
